tile_loader: RTL and testbench
==============================

# tile_loader

Upstream feeder for the dispatcher. It accepts a serial stream of 32-bit words over a valid/ready handshake and assembles a 4x4 R tile, plus an optional 4x4 A tile, in row-major order. It then holds both tiles stable and drives the dispatcher's `count` and `shouldAdd` inputs through one full dispatch sequence. When the sequence ends it signals completion and returns to accept the next tile.

## Interface
- `DISPATCH_CYCLES`, default 8: number of `count` steps per tile (0 .. DISPATCH_CYCLES-1); legal range 1..31.
- `clk`  in  1: sole clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: loader can accept a word this cycle.
- `in_data`  in  32: tile word (IEEE-754 single or raw bits; not interpreted).
- `in_add`  in  1: sampled only with the first word of a tile; 1 = an A tile follows the R tile.
- `r11` .. `r44`  out  32 each: R tile registers, row-major (`r11` = word 0, `r44` = word 15).
- `a11` .. `a44`  out  32 each: A tile registers, row-major.
- `count`  out  5: dispatch step index to the dispatcher.
- `shouldAdd`  out  1: mode flag to the dispatcher.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at the end of the dispatch sequence.

## Operation
- Handshake: a word is accepted at a posedge where `in_valid & in_ready` is true. `in_ready` is 1 in IDLE, LOAD_R and LOAD_A, and 0 in DISPATCH, DONE, and any cycle with `rst` high.
- The 4-bit index `idx` selects the destination register. It advances only on an accepted word and wraps 15 -> 0 at each tile boundary.
- IDLE
  - On accept: write `r11`, latch `add_mode` from `in_add`, clear all `a` registers to 0, set `idx` = 1, go to LOAD_R.
- LOAD_R
  - On accept: write R[idx] and increment `idx`.
  - On accepting word 15: go to LOAD_A if `add_mode`, else go to DISPATCH.
- LOAD_A
  - On accept: write A[idx].
  - On accepting word 15: go to DISPATCH.
- DISPATCH
  - `count` starts at 0 and increments by 1 per cycle.
  - In the cycle `count` = DISPATCH_CYCLES-1, the next state is DONE.
  - `shouldAdd` = `add_mode` throughout.
- DONE: `done` = 1 for one cycle; `count` returns to 0; go to IDLE.
- Outside DISPATCH: `count` = 0 and `shouldAdd` = 0.
- R and A registers are written only during loading. They hold their value through DISPATCH, DONE and IDLE until overwritten by the next tile.
- Words presented while `in_ready` = 0 are not consumed; the source must hold them.
- Reset state: IDLE, `idx` = 0, `add_mode` = 0, all R/A registers = 0, `count` = 0, `shouldAdd` = 0, `busy` = 0, `done` = 0.
- Reset mid-operation (any state) discards the partial tile and clears all registers. `rst` wins over a simultaneous handshake.

## Timing
- Latency is zero bubbles: with `in_valid` held high, word k is accepted at edge k.
- R-only tile: last word accepted at edge 15 (counting the first accept as edge 0).
  - DISPATCH covers cycles 16 .. 16+DISPATCH_CYCLES-1.
  - `done` is high in cycle 16+DISPATCH_CYCLES.
  - IDLE, and the next first word can be accepted, at the edge ending cycle 17+DISPATCH_CYCLES.
- Add tile: same schedule shifted by 16 cycles.
- Registers written at edge k are visible on the outputs in cycle k+1. All outputs are registered.
- `busy` rises in the cycle after the first accepted word and falls in the cycle after DONE.

## Test plan
1. Reset: drive `rst` high for 2 cycles with `in_valid` = 1.
   - During reset: `in_ready` = 0.
   - After release: all `r`/`a` = 0, `count` = 0, `shouldAdd` = 0, `busy` = 0, `done` = 0, `in_ready` = 1.
2. R-only tile: `in_add` = 0, words 0x00000000 .. 0x0000000F with `in_valid` held high.
   - Registers: `r11` = 0x0, `r24` = 0x7, `r44` = 0xF; all `a` = 0.
   - `count` steps 0..7 over 8 consecutive cycles with `shouldAdd` = 0.
   - `done` pulses once; `in_ready` is low for 9 cycles.
3. Add tile: `in_add` = 1, R = 0x00000000, 0x3f800000, 0x40000000 .. 0x41700000 (0.0..15.0), then 16 × 0x3f800000.
   - Registers: `r12` = 0x3f800000, `r44` = 0x41700000, all `a` = 0x3f800000.
   - `shouldAdd` = 1 for exactly the 8 DISPATCH cycles.
   - After a following R-only tile, all `a` read 0.
4. Bubbles: test 2 with `in_valid` toggling every cycle.
   - Identical register contents; dispatch starts 1 cycle after the 16th accept.
5. Backpressure: keep `in_valid` high with word 0xDEADBEEF during DISPATCH.
   - Not consumed: R registers unchanged.
   - Accepted as the new `r11` only in IDLE after `done`.
6. Reset mid-load: assert `rst` after 7 accepted words.
   - IDLE, all registers 0.
   - A fresh 16-word tile then loads and dispatches exactly as in test 2.

Source files
------------

// File: rtl/tile_loader.sv
// Assembles a 4x4 R tile (and optional 4x4 A tile) from a serial word stream,
// then holds them and steps the dispatcher's count/shouldAdd through one sequence.
module tile_loader #(
  parameter int DISPATCH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_add,
  output logic [31:0] r11, r12, r13, r14,
  output logic [31:0] r21, r22, r23, r24,
  output logic [31:0] r31, r32, r33, r34,
  output logic [31:0] r41, r42, r43, r44,
  output logic [31:0] a11, a12, a13, a14,
  output logic [31:0] a21, a22, a23, a24,
  output logic [31:0] a31, a32, a33, a34,
  output logic [31:0] a41, a42, a43, a44,
  output logic [4:0]  count,
  output logic        shouldAdd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_R,
    S_LOAD_A,
    S_DISPATCH,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_COUNT = 5'(DISPATCH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        add_mode_q, add_mode_d;
  logic [4:0]  count_q, count_d;
  logic        should_add_q, should_add_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] a_q [16];
  logic [31:0] a_d [16];
  logic        load_state;
  logic        accept;

  // Reset forces ready low so a word offered during reset is never consumed.
  assign load_state = (state_q == S_IDLE) || (state_q == S_LOAD_R) || (state_q == S_LOAD_A);
  assign in_ready   = load_state && !rst;
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    add_mode_d = add_mode_q;
    count_d    = 5'd0;
    r_d        = r_q;
    a_d        = a_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          r_d[0]     = in_data;
          add_mode_d = in_add;
          for (int i = 0; i < 16; i++) a_d[i] = 32'd0;
          idx_d      = 4'd1;
          state_d    = S_LOAD_R;
        end
      end
      S_LOAD_R: begin
        if (accept) begin
          r_d[idx_q] = in_data;
          idx_d      = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = add_mode_q ? S_LOAD_A : S_DISPATCH;
        end
      end
      S_LOAD_A: begin
        if (accept) begin
          a_d[idx_q] = in_data;
          idx_d      = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (count_q == LAST_COUNT) state_d = S_DONE;
        else                       count_d = count_q + 5'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they align with it.
    should_add_d = (state_d == S_DISPATCH) && add_mode_d;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      add_mode_q   <= 1'b0;
      count_q      <= 5'd0;
      should_add_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_q[i] <= 32'd0;
        a_q[i] <= 32'd0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      add_mode_q   <= add_mode_d;
      count_q      <= count_d;
      should_add_q <= should_add_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      for (int i = 0; i < 16; i++) begin
        r_q[i] <= r_d[i];
        a_q[i] <= a_d[i];
      end
    end
  end

  assign count     = count_q;
  assign shouldAdd = should_add_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign r11 = r_q[0];  assign r12 = r_q[1];  assign r13 = r_q[2];  assign r14 = r_q[3];
  assign r21 = r_q[4];  assign r22 = r_q[5];  assign r23 = r_q[6];  assign r24 = r_q[7];
  assign r31 = r_q[8];  assign r32 = r_q[9];  assign r33 = r_q[10]; assign r34 = r_q[11];
  assign r41 = r_q[12]; assign r42 = r_q[13]; assign r43 = r_q[14]; assign r44 = r_q[15];

  assign a11 = a_q[0];  assign a12 = a_q[1];  assign a13 = a_q[2];  assign a14 = a_q[3];
  assign a21 = a_q[4];  assign a22 = a_q[5];  assign a23 = a_q[6];  assign a24 = a_q[7];
  assign a31 = a_q[8];  assign a32 = a_q[9];  assign a33 = a_q[10]; assign a34 = a_q[11];
  assign a41 = a_q[12]; assign a42 = a_q[13]; assign a43 = a_q[14]; assign a44 = a_q[15];

endmodule

// File: tb/tb_tile_loader.sv
// Bench for tile_loader: directed and randomized tiles checked against a
// tile-level model of register contents and dispatch timing.
module tb_tile_loader;
  localparam int DC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_add;
  logic [31:0] r11, r12, r13, r14, r21, r22, r23, r24;
  logic [31:0] r31, r32, r33, r34, r41, r42, r43, r44;
  logic [31:0] a11, a12, a13, a14, a21, a22, a23, a24;
  logic [31:0] a31, a32, a33, a34, a41, a42, a43, a44;
  logic [4:0]  count;
  logic        shouldAdd;
  logic        busy;
  logic        done;

  int checks = 0;
  int passed = 0;

  logic [31:0] exp_r [16];
  logic [31:0] exp_a [16];
  logic [31:0] obs_r [16];
  logic [31:0] obs_a [16];
  logic [31:0] words [32];

  tile_loader #(.DISPATCH_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_add(in_add),
    .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r21(r21), .r22(r22), .r23(r23), .r24(r24),
    .r31(r31), .r32(r32), .r33(r33), .r34(r34), .r41(r41), .r42(r42), .r43(r43), .r44(r44),
    .a11(a11), .a12(a12), .a13(a13), .a14(a14), .a21(a21), .a22(a22), .a23(a23), .a24(a24),
    .a31(a31), .a32(a32), .a33(a33), .a34(a34), .a41(a41), .a42(a42), .a43(a43), .a44(a44),
    .count(count), .shouldAdd(shouldAdd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs_r[0] = r11;  obs_r[1] = r12;  obs_r[2] = r13;  obs_r[3] = r14;
    obs_r[4] = r21;  obs_r[5] = r22;  obs_r[6] = r23;  obs_r[7] = r24;
    obs_r[8] = r31;  obs_r[9] = r32;  obs_r[10] = r33; obs_r[11] = r34;
    obs_r[12] = r41; obs_r[13] = r42; obs_r[14] = r43; obs_r[15] = r44;
    obs_a[0] = a11;  obs_a[1] = a12;  obs_a[2] = a13;  obs_a[3] = a14;
    obs_a[4] = a21;  obs_a[5] = a22;  obs_a[6] = a23;  obs_a[7] = a24;
    obs_a[8] = a31;  obs_a[9] = a32;  obs_a[10] = a33; obs_a[11] = a34;
    obs_a[12] = a41; obs_a[13] = a42; obs_a[14] = a43; obs_a[15] = a44;
  end

  task automatic zero_model();
    for (int j = 0; j < 16; j++) begin
      exp_r[j] = 32'd0;
      exp_a[j] = 32'd0;
    end
  endtask

  // Offers words[0..n-1]; mode 0 = valid held, 1 = valid toggles, 2 = random gaps.
  task automatic drive_tile(input int n, input bit add, input int mode);
    int i;
    int guard;
    bit v;
    bit rdy;
    bit ph;
    i = 0; guard = 0; ph = 1'b0;
    while (i < n && guard < 400) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       begin v = ph; ph = ~ph; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = words[i];
      in_add   = (i == 0) ? add : 1'($urandom);
      #1 rdy = in_ready;
      @(posedge clk);
      if (v && rdy) i++;
      guard++;
    end
    if (i < n) begin
      checks++;
      $display("FAIL load_timeout accepted=%0d required=%0d", i, n);
    end
    if (n >= 16) begin
      for (int j = 0; j < 16; j++) begin
        exp_r[j] = words[j];
        exp_a[j] = add ? words[16 + j] : 32'd0;
      end
    end
  endtask

  // Walks the cycles after the last accepted word: DC dispatch cycles, one done cycle, then idle.
  task automatic check_dispatch(input bit add, input bit hold);
    logic [8:0] exp_s;
    logic [8:0] obs_s;
    bit ok;
    int bad;
    for (int k = 1; k <= DC + 2; k++) begin
      @(negedge clk);
      if (hold) begin
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
      end else begin
        in_valid = 1'b0;
      end
      if (k <= DC)          exp_s = {5'(k - 1), add, 1'b0, 1'b1, 1'b0};
      else if (k == DC + 1) exp_s = {5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      else                  exp_s = {5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
      #1 obs_s = {count, shouldAdd, done, busy, in_ready};
      checks++;
      if (obs_s !== exp_s)
        $display("FAIL dispatch_k%0d {count,sa,done,busy,rdy} got=%0d,%b,%b,%b,%b want=%0d,%b,%b,%b,%b",
                 k, obs_s[8:4], obs_s[3], obs_s[2], obs_s[1], obs_s[0],
                 exp_s[8:4], exp_s[3], exp_s[2], exp_s[1], exp_s[0]);
      else passed++;
      if (k == 1 || k == DC + 1) begin
        ok = 1'b1; bad = 0;
        for (int j = 0; j < 16; j++)
          if (ok && (obs_r[j] !== exp_r[j] || obs_a[j] !== exp_a[j])) begin
            ok = 1'b0; bad = j;
          end
        checks++;
        if (!ok)
          $display("FAIL regs_k%0d idx=%0d r got=%h want=%h a got=%h want=%h",
                   k, bad, obs_r[bad], exp_r[bad], obs_a[bad], exp_a[bad]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h12345678; in_add = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) $display("FAIL reset_ready cyc%0d got=%b want=0", c, in_ready);
      else passed++;
    end
    rst = 1'b0; in_valid = 1'b0;
    zero_model();
    #1;
    checks++;
    if ({count, shouldAdd, done, busy, in_ready} !== {5'd0, 4'b0001})
      $display("FAIL reset_status got=%0d,%b,%b,%b,%b want=0,0,0,0,1",
               count, shouldAdd, done, busy, in_ready);
    else passed++;
    ok = 1'b1;
    for (int j = 0; j < 16; j++) if (obs_r[j] !== 32'd0 || obs_a[j] !== 32'd0) ok = 1'b0;
    checks++;
    if (!ok) $display("FAIL reset_regs got=nonzero want=all zero");
    else passed++;
  endtask

  task automatic test_r_only();
    for (int j = 0; j < 32; j++) words[j] = 32'(j);
    drive_tile(16, 1'b0, 0);
    check_dispatch(1'b0, 1'b0);
    checks++;
    if (r24 !== 32'h7 || r44 !== 32'hF)
      $display("FAIL r_only_named r24=%h r44=%h want=7,f", r24, r44);
    else passed++;
  endtask

  task automatic test_add_tile();
    logic [31:0] fl [16];
    fl = '{32'h00000000, 32'h3f800000, 32'h40000000, 32'h40400000,
           32'h40800000, 32'h40a00000, 32'h40c00000, 32'h40e00000,
           32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
           32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};
    for (int j = 0; j < 16; j++) begin
      words[j]      = fl[j];
      words[16 + j] = 32'h3f800000;
    end
    drive_tile(32, 1'b1, 0);
    check_dispatch(1'b1, 1'b0);
    // A following R-only tile must clear the A registers.
    for (int j = 0; j < 16; j++) words[j] = $urandom;
    drive_tile(16, 1'b0, 0);
    check_dispatch(1'b0, 1'b0);
  endtask

  task automatic test_bubbles();
    for (int j = 0; j < 32; j++) words[j] = 32'(j);
    drive_tile(16, 1'b0, 1);
    check_dispatch(1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int j = 0; j < 16; j++) words[j] = $urandom;
    drive_tile(16, 1'b0, 0);
    check_dispatch(1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (r11 !== 32'hDEADBEEF || r12 !== exp_r[1] || busy !== 1'b1)
      $display("FAIL backpressure_accept r11=%h r12=%h busy=%b want=deadbeef,%h,1",
               r11, r12, busy, exp_r[1]);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    zero_model();
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    for (int j = 0; j < 16; j++) words[j] = $urandom;
    drive_tile(7, 1'b1, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    zero_model();
    #1;
    ok = 1'b1;
    for (int j = 0; j < 16; j++) if (obs_r[j] !== 32'd0 || obs_a[j] !== 32'd0) ok = 1'b0;
    checks++;
    if (!ok || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midload_reset regs_zero=%b busy=%b rdy=%b want=1,0,1", ok, busy, in_ready);
    else passed++;
    for (int j = 0; j < 32; j++) words[j] = 32'(j);
    drive_tile(16, 1'b0, 0);
    check_dispatch(1'b0, 1'b0);
  endtask

  task automatic test_random_tiles();
    bit add;
    for (int t = 0; t < 6; t++) begin
      add = 1'($urandom);
      for (int j = 0; j < 32; j++) words[j] = $urandom;
      drive_tile(add ? 32 : 16, add, 2);
      check_dispatch(add, 1'b0);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_data = 32'd0; in_add = 1'b0; rst = 1'b1;
    zero_model();
    test_reset();
    test_r_only();
    test_add_tile();
    test_bubbles();
    test_backpressure();
    test_reset_mid_load();
    test_random_tiles();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
